// File: rtl/mem_access_arbiter.sv
// Shares the unified ROM/RAM memory between an instruction-fetch port (0) and a
// data port (1): round-robin grant, one transaction in flight, ROM writes dropped.
module mem_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE = ADDR_WIDTH'(32'h1001_0000),
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic                  ram_q, ram_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  sel_port;
  logic [ADDR_WIDTH-1:0] sel_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      ram_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      ram_q        <= ram_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    ram_d        = ram_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    sel_port     = 1'b0;
    sel_addr     = addr0_i;

    case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie the port that did not win last time is served.
          sel_port     = (req0_i && req1_i) ? ~last_grant_q : req1_i;
          sel_addr     = sel_port ? addr1_i : addr0_i;
          grant_d      = sel_port;
          last_grant_d = sel_port;
          we_d         = sel_port ? we1_i : we0_i;
          addr_d       = sel_addr;
          wdata_d      = sel_port ? wdata1_i : wdata0_i;
          ram_d        = (sel_addr >= RAM_BASE);
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = LAT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          rdata_d = mem_rdata_i;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state so no requester input reaches them combinationally.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    ack0_o      = (state_q == ST_DONE) && !grant_q;
    ack1_o      = (state_q == ST_DONE) && grant_q;
    err_o       = (state_q == ST_DONE) && we_q && !ram_q;
    mem_we_o    = (state_q == ST_ISSUE) && we_q && ram_q;
    mem_addr_o  = (state_q == ST_IDLE) ? '0 : addr_q;
    mem_wdata_o = (state_q == ST_IDLE) ? '0 : wdata_q;
    rdata_o     = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one instance at READ_LATENCY=1 and one at
// READ_LATENCY=3, each backed by a small ROM/RAM model with matching read latency.
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  always #5 clk = ~clk;

  logic        a_req0, a_we0, a_req1, a_we1;
  logic [31:0] a_addr0, a_wdata0, a_addr1, a_wdata1;
  logic        a_ack0, a_ack1, a_err, a_busy, a_mem_we;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_req0, b_we0, b_req1, b_we1;
  logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
  logic        b_ack0, b_ack1, b_err, b_busy, b_mem_we;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int test_count = 0;
  int fail_count = 0;

  mem_access_arbiter #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .req0_i(a_req0), .we0_i(a_we0), .addr0_i(a_addr0), .wdata0_i(a_wdata0),
    .req1_i(a_req1), .we1_i(a_we1), .addr1_i(a_addr1), .wdata1_i(a_wdata1),
    .ack0_o(a_ack0), .ack1_o(a_ack1), .err_o(a_err), .rdata_o(a_rdata), .busy_o(a_busy),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_we_o(a_mem_we),
    .mem_rdata_i(a_mem_rdata)
  );

  mem_access_arbiter #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .wdata0_i(b_wdata0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .wdata1_i(b_wdata1),
    .ack0_o(b_ack0), .ack1_o(b_ack1), .err_o(b_err), .rdata_o(b_rdata), .busy_o(b_busy),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_we_o(b_mem_we),
    .mem_rdata_i(b_mem_rdata)
  );

  // 16-word memory: bit 28 separates ROM (0x0040_xxxx) from RAM (0x1001_xxxx).
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] a_rd_p1, b_rd_p1, b_rd_p2, b_rd_p3;

  function automatic logic [3:0] idx(input logic [31:0] addr);
    return {addr[28], addr[4:2]};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[0] <= 32'hDEAD_BEEF;
      mem_a[2] <= 32'hCAFE_F00D;
      mem_b[0] <= 32'hDEAD_BEEF;
      mem_b[2] <= 32'hCAFE_F00D;
    end else begin
      if (a_mem_we) mem_a[idx(a_mem_addr)] <= a_mem_wdata;
      if (b_mem_we) mem_b[idx(b_mem_addr)] <= b_mem_wdata;
    end
    a_rd_p1 <= mem_a[idx(a_mem_addr)];
    b_rd_p1 <= mem_b[idx(b_mem_addr)];
    b_rd_p2 <= b_rd_p1;
    b_rd_p3 <= b_rd_p2;
  end

  assign a_mem_rdata = a_rd_p1;
  assign b_mem_rdata = b_rd_p3;

  // Holds the currently driven inputs for the given number of clock edges, then
  // lands 1 time unit after the last edge where outputs are stable.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    {a_req0, a_we0, a_req1, a_we1} = '0;
    {a_addr0, a_wdata0, a_addr1, a_wdata1} = '0;
    {b_req0, b_we0, b_req1, b_we1} = '0;
    {b_addr0, b_wdata0, b_addr1, b_wdata1} = '0;
    applyStimulus(2);

    // Reset state
    checkOutput("rst_ack0", a_ack0, 0);
    checkOutput("rst_ack1", a_ack1, 0);
    checkOutput("rst_err", a_err, 0);
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_rdata", a_rdata, 0);
    checkOutput("rst_mem_we", a_mem_we, 0);
    checkOutput("rst_mem_addr", a_mem_addr, 0);
    checkOutput("rst_mem_wdata", a_mem_wdata, 0);
    checkOutput("rst_b_busy", b_busy, 0);
    reset = 1'b0;
    mem_init = 1'b0;
    applyStimulus(1);

    // Test 1: ROM read on port 0, ack at t+3
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h0040_0000;
    applyStimulus(1);
    checkOutput("t1_busy", a_busy, 1);
    checkOutput("t1_mem_addr", a_mem_addr, 32'h0040_0000);
    checkOutput("t1_mem_we", a_mem_we, 0);
    applyStimulus(1);
    checkOutput("t1_ack0_early", a_ack0, 0);
    checkOutput("t1_rdata_early", a_rdata, 0);
    applyStimulus(1);
    checkOutput("t1_ack0", a_ack0, 1);
    checkOutput("t1_ack1", a_ack1, 0);
    checkOutput("t1_rdata", a_rdata, 32'hDEAD_BEEF);
    checkOutput("t1_err", a_err, 0);
    a_req0 = 1'b0;
    applyStimulus(1);
    checkOutput("t1_ack0_pulse", a_ack0, 0);
    checkOutput("t1_idle", a_busy, 0);
    checkOutput("t1_idle_addr", a_mem_addr, 0);

    // Test 2: RAM write on port 1, then read back
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h1001_0004; a_wdata1 = 32'h1234_5678;
    applyStimulus(1);
    checkOutput("t2_mem_we", a_mem_we, 1);
    checkOutput("t2_mem_addr", a_mem_addr, 32'h1001_0004);
    checkOutput("t2_mem_wdata", a_mem_wdata, 32'h1234_5678);
    applyStimulus(1);
    checkOutput("t2_mem_we_drop", a_mem_we, 0);
    checkOutput("t2_ack1", a_ack1, 1);
    checkOutput("t2_err", a_err, 0);
    checkOutput("t2_rdata_held", a_rdata, 32'hDEAD_BEEF);
    a_req1 = 1'b0;
    applyStimulus(1);
    a_req1 = 1'b1; a_we1 = 1'b0;
    applyStimulus(3);
    checkOutput("t2_rd_ack1", a_ack1, 1);
    checkOutput("t2_rd_rdata", a_rdata, 32'h1234_5678);
    a_req1 = 1'b0;
    applyStimulus(1);

    // Test 3: ROM write is dropped and flagged
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h0040_0008; a_wdata1 = 32'hBAD0_BAD0;
    applyStimulus(1);
    checkOutput("t3_mem_we", a_mem_we, 0);
    checkOutput("t3_busy", a_busy, 1);
    applyStimulus(1);
    checkOutput("t3_mem_we_done", a_mem_we, 0);
    checkOutput("t3_ack1", a_ack1, 1);
    checkOutput("t3_err", a_err, 1);
    a_req1 = 1'b0;
    applyStimulus(1);
    checkOutput("t3_err_pulse", a_err, 0);
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h0040_0008;
    applyStimulus(3);
    checkOutput("t3_rd_ack0", a_ack0, 1);
    checkOutput("t3_rd_rdata", a_rdata, 32'hCAFE_F00D);
    checkOutput("t3_rd_err", a_err, 0);
    a_req0 = 1'b0;
    applyStimulus(1);

    // Test 4: both ports held; fresh reset so port 0 wins the first tie
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 32'h1001_0010; a_wdata0 = 32'hA0A0_A0A0;
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h1001_0014; a_wdata1 = 32'hB1B1_B1B1;
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("t4_ack0_c%0d", k), a_ack0, (k == 2 || k == 8) ? 1 : 0);
      checkOutput($sformatf("t4_ack1_c%0d", k), a_ack1, (k == 5 || k == 11) ? 1 : 0);
      if (k == 1) checkOutput("t4_first_addr", a_mem_addr, 32'h1001_0010);
      if (k == 4) checkOutput("t4_second_addr", a_mem_addr, 32'h1001_0014);
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
    applyStimulus(1);
    checkOutput("t4_idle", a_busy, 0);

    // Test 5: reset during the ISSUE cycle of a RAM write
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h1001_0018; a_wdata1 = 32'h55AA_55AA;
    applyStimulus(1);
    checkOutput("t5_mem_we", a_mem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_mem_we_async", a_mem_we, 0);
    checkOutput("t5_busy_async", a_busy, 0);
    a_req1 = 1'b0;
    applyStimulus(1);
    checkOutput("t5_no_ack1", a_ack1, 0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("t5_no_ack1_after", a_ack1, 0);
    checkOutput("t5_idle", a_busy, 0);
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h1001_0018;
    applyStimulus(3);
    checkOutput("t5_rd_ack0", a_ack0, 1);
    checkOutput("t5_rd_unwritten", a_rdata, 32'h0);
    a_req0 = 1'b0;
    applyStimulus(1);
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h1001_0018; a_wdata1 = 32'h0F0F_0F0F;
    applyStimulus(1);
    checkOutput("t5_wr_mem_we", a_mem_we, 1);
    applyStimulus(1);
    checkOutput("t5_wr_ack1", a_ack1, 1);
    a_req1 = 1'b0;
    applyStimulus(1);

    // Test 6: READ_LATENCY=3 instance, port 1 wiggles while port 0 is served
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 32'h0040_0000;
    applyStimulus(1);
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 32'h1001_0000; b_wdata1 = 32'h7777_7777;
    checkOutput("t6_mem_addr", b_mem_addr, 32'h0040_0000);
    applyStimulus(1);
    b_addr1 = 32'h1001_0004;
    checkOutput("t6_mem_addr_held", b_mem_addr, 32'h0040_0000);
    checkOutput("t6_mem_we", b_mem_we, 0);
    applyStimulus(1);
    b_req1 = 1'b0;
    checkOutput("t6_ack0_t3", b_ack0, 0);
    applyStimulus(1);
    checkOutput("t6_ack0_t4", b_ack0, 0);
    checkOutput("t6_mem_we_wait", b_mem_we, 0);
    applyStimulus(1);
    checkOutput("t6_ack0_t5", b_ack0, 1);
    checkOutput("t6_ack1_t5", b_ack1, 0);
    checkOutput("t6_rdata", b_rdata, 32'hDEAD_BEEF);
    b_req0 = 1'b0;
    applyStimulus(1);
    checkOutput("t6_ack1_none", b_ack1, 0);
    checkOutput("t6_idle", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
